// File: rtl/riscv_ctrl_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// riscv_ctrl_pkg : state, opcode and mux-select encodings for multicycle_control
// Revision: 1.0
// ---------------------------------------------------------------------------
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWRITE = 4'd4,
    S_EXECUTE  = 4'd5,
    S_ALUWB    = 4'd6,
    S_MEMWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_HALT     = 4'd9
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_BEQ = 3'b000;

  localparam logic [1:0] ALUSRCA_PC    = 2'b00;
  localparam logic [1:0] ALUSRCA_OLDPC = 2'b01;
  localparam logic [1:0] ALUSRCA_RS1   = 2'b10;

  localparam logic [1:0] ALUSRCB_RS2  = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM  = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic       irwrite;
    logic       pcwrite;
    logic       pcsrc;
    logic       memread;
    logic       memwrite;
    logic       regiwrite;
    logic       memtoreg;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic       halted;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

endpackage
`default_nettype wire

// File: rtl/multicycle_ctrl_decode.sv
`default_nettype none
// ---------------------------------------------------------------------------
// multicycle_ctrl_decode : combinational strobe table indexed by FSM state
// Revision: 1.0
// ---------------------------------------------------------------------------
module multicycle_ctrl_decode
  import riscv_ctrl_pkg::*;
(
  input  state_e     estado_i,
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic       mem_ready_i,
  input  logic       zero_i,
  input  logic       run_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o = CTRL_IDLE;
    case (estado_i)
      S_FETCH: begin
        ctrl_o.memread = run_i;
        ctrl_o.alusrca = ALUSRCA_PC;
        ctrl_o.alusrcb = ALUSRCB_FOUR;
        ctrl_o.aluop   = ALUOP_ADD;
        if (run_i && mem_ready_i) begin
          ctrl_o.irwrite = 1'b1;
          ctrl_o.pcwrite = 1'b1;
          ctrl_o.pcsrc   = 1'b0;
        end
      end
      S_DECODE: begin
        // Precompute the branch target into ALUOut while the opcode is decoded.
        ctrl_o.alusrca = ALUSRCA_OLDPC;
        ctrl_o.alusrcb = ALUSRCB_IMM;
        ctrl_o.aluop   = ALUOP_ADD;
      end
      S_MEMADR: begin
        ctrl_o.alusrca = ALUSRCA_RS1;
        ctrl_o.alusrcb = ALUSRCB_IMM;
        ctrl_o.aluop   = ALUOP_ADD;
      end
      S_MEMREAD:  ctrl_o.memread  = 1'b1;
      S_MEMWRITE: ctrl_o.memwrite = 1'b1;
      S_EXECUTE: begin
        ctrl_o.alusrca = ALUSRCA_RS1;
        ctrl_o.alusrcb = (opcode_i == OP_ITYPE) ? ALUSRCB_IMM : ALUSRCB_RS2;
        ctrl_o.aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl_o.regiwrite = 1'b1;
        ctrl_o.memtoreg  = 1'b0;
      end
      S_MEMWB: begin
        ctrl_o.regiwrite = 1'b1;
        ctrl_o.memtoreg  = 1'b1;
      end
      S_BRANCH: begin
        ctrl_o.alusrca = ALUSRCA_RS1;
        ctrl_o.alusrcb = ALUSRCB_RS2;
        ctrl_o.aluop   = ALUOP_SUB;
        if (funct3_i == F3_BEQ) begin
          ctrl_o.pcwrite = zero_i;
          ctrl_o.pcsrc   = 1'b1;
        end
      end
      S_HALT:  ctrl_o.halted = 1'b1;
      default: ctrl_o = CTRL_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ---------------------------------------------------------------------------
// multicycle_control : main FSM of the multicycle RV32I datapath plus instret
// Revision: 1.0
// ---------------------------------------------------------------------------
module multicycle_control
  import riscv_ctrl_pkg::*;
#(
  parameter int STATE_W = 4,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic [6:0]         opcode,
  input  logic [2:0]         funct3,
  input  logic               funct7b5,
  input  logic               zero,
  input  logic               mem_ready,
  output logic [STATE_W-1:0] estado,
  output logic               irwrite,
  output logic               pcwrite,
  output logic               pcsrc,
  output logic               memread,
  output logic               memwrite,
  output logic               regiwrite,
  output logic               memtoreg,
  output logic [1:0]         alusrca,
  output logic [1:0]         alusrcb,
  output logic [1:0]         aluop,
  output logic               halted,
  output logic [CNT_W-1:0]   instret
);

  state_e           state_q, state_d;
  logic             retire_d;
  logic [CNT_W-1:0] instret_q;
  ctrl_t            ctrl_raw, ctrl_out;
  logic             unused_funct7b5;

  // ALU function selection happens downstream; this FSM never needs instr[30].
  assign unused_funct7b5 = funct7b5;

  always_comb begin
    state_d  = state_q;
    retire_d = 1'b0;
    case (state_q)
      S_FETCH:  if (run && mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE, OP_ITYPE: state_d = S_EXECUTE;
          OP_BRANCH:          state_d = S_BRANCH;
          default:            state_d = S_HALT;
        endcase
      end
      S_MEMADR:  state_d = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD: if (mem_ready) state_d = S_MEMWB;
      S_MEMWRITE: begin
        if (mem_ready) begin
          state_d  = S_FETCH;
          retire_d = 1'b1;
        end
      end
      S_EXECUTE: state_d = S_ALUWB;
      S_ALUWB, S_MEMWB, S_BRANCH: begin
        state_d  = S_FETCH;
        retire_d = 1'b1;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire_d) instret_q <= instret_q + CNT_W'(1);
    end
  end

  multicycle_ctrl_decode u_decode (
    .estado_i    (state_q),
    .opcode_i    (opcode),
    .funct3_i    (funct3),
    .mem_ready_i (mem_ready),
    .zero_i      (zero),
    .run_i       (run),
    .ctrl_o      (ctrl_raw)
  );

  // Reset silences every strobe in the same cycle so no write escapes mid-instruction.
  assign ctrl_out = rst ? CTRL_IDLE : ctrl_raw;

  assign estado    = STATE_W'(state_q);
  assign instret   = instret_q;
  assign irwrite   = ctrl_out.irwrite;
  assign pcwrite   = ctrl_out.pcwrite;
  assign pcsrc     = ctrl_out.pcsrc;
  assign memread   = ctrl_out.memread;
  assign memwrite  = ctrl_out.memwrite;
  assign regiwrite = ctrl_out.regiwrite;
  assign memtoreg  = ctrl_out.memtoreg;
  assign alusrca   = ctrl_out.alusrca;
  assign alusrcb   = ctrl_out.alusrcb;
  assign aluop     = ctrl_out.aluop;
  assign halted    = ctrl_out.halted;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_multicycle_control : directed scoreboard bench for multicycle_control
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        rst, run, funct7b5, zero, mem_ready;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [3:0]  estado;
  logic        irwrite, pcwrite, pcsrc, memread, memwrite, regiwrite, memtoreg, halted;
  logic [1:0]  alusrca, alusrcb, aluop;
  logic [31:0] instret;

  multicycle_control #(.STATE_W(4), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .run(run), .opcode(opcode), .funct3(funct3),
    .funct7b5(funct7b5), .zero(zero), .mem_ready(mem_ready),
    .estado(estado), .irwrite(irwrite), .pcwrite(pcwrite), .pcsrc(pcsrc),
    .memread(memread), .memwrite(memwrite), .regiwrite(regiwrite),
    .memtoreg(memtoreg), .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop),
    .halted(halted), .instret(instret)
  );

  always #5 clk = ~clk;

  // {irwrite,pcwrite,pcsrc,memread,memwrite,regiwrite,memtoreg,alusrca,alusrcb,aluop,halted}
  localparam logic [13:0] X_RST        = 14'b0000000_00_00_00_0;
  localparam logic [13:0] X_FETCH_GO   = 14'b1101000_00_01_00_0;
  localparam logic [13:0] X_FETCH_WAIT = 14'b0001000_00_01_00_0;
  localparam logic [13:0] X_FETCH_IDLE = 14'b0000000_00_01_00_0;
  localparam logic [13:0] X_DECODE     = 14'b0000000_01_10_00_0;
  localparam logic [13:0] X_MEMADR     = 14'b0000000_10_10_00_0;
  localparam logic [13:0] X_MEMREAD    = 14'b0001000_00_00_00_0;
  localparam logic [13:0] X_MEMWRITE   = 14'b0000100_00_00_00_0;
  localparam logic [13:0] X_EXEC_R     = 14'b0000000_10_00_10_0;
  localparam logic [13:0] X_EXEC_I     = 14'b0000000_10_10_10_0;
  localparam logic [13:0] X_ALUWB      = 14'b0000010_00_00_00_0;
  localparam logic [13:0] X_MEMWB      = 14'b0000011_00_00_00_0;
  localparam logic [13:0] X_BEQ_T      = 14'b0110000_10_00_01_0;
  localparam logic [13:0] X_BEQ_N      = 14'b0010000_10_00_01_0;
  localparam logic [13:0] X_BNE        = 14'b0000000_10_00_01_0;
  localparam logic [13:0] X_HALT       = 14'b0000000_00_00_00_1;

  typedef struct packed {
    logic [31:0] step;
    logic [3:0]  st;
    logic [13:0] x;
    logic [31:0] ir;
  } exp_t;

  exp_t        sb_q[$];
  int          n_vec  = 0;
  int          n_miss = 0;
  int          n_step = 0;
  logic [13:0] act_x;

  assign act_x = {irwrite, pcwrite, pcsrc, memread, memwrite, regiwrite, memtoreg,
                  alusrca, alusrcb, aluop, halted};

  // Issue one cycle: record what the DUT must show during it, then advance.
  task automatic cyc(input logic [3:0] st, input logic [13:0] x, input logic [31:0] ir);
    exp_t e;
    e.step = n_step;
    e.st   = st;
    e.x    = x;
    e.ir   = ir;
    sb_q.push_back(e);
    n_step++;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      n_vec++;
      if (estado !== e.st || act_x !== e.x || instret !== e.ir) begin
        n_miss++;
        $display("FAIL step%0d: got estado=%0d strobes=%b instret=%0d, want estado=%0d strobes=%b instret=%0d",
                 e.step, estado, act_x, instret, e.st, e.x, e.ir);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, queue=%0d", sb_q.size());
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; run = 1'b1; mem_ready = 1'b1; zero = 1'b0;
    opcode = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b0;
    @(posedge clk); #1;

    // Reset held with run=1
    repeat (3) cyc(4'd0, X_RST, 0);
    rst = 1'b0;

    // add
    cyc(4'd0, X_FETCH_GO, 0);
    cyc(4'd1, X_DECODE, 0);
    cyc(4'd5, X_EXEC_R, 0);
    cyc(4'd6, X_ALUWB, 0);

    // lw with three wait cycles in MEMREAD
    opcode = 7'b0000011;
    cyc(4'd0, X_FETCH_GO, 1);
    cyc(4'd1, X_DECODE, 1);
    cyc(4'd2, X_MEMADR, 1);
    mem_ready = 1'b0;
    repeat (3) cyc(4'd3, X_MEMREAD, 1);
    mem_ready = 1'b1;
    cyc(4'd3, X_MEMREAD, 1);
    cyc(4'd7, X_MEMWB, 1);

    // addi
    opcode = 7'b0010011;
    cyc(4'd0, X_FETCH_GO, 2);
    cyc(4'd1, X_DECODE, 2);
    cyc(4'd5, X_EXEC_I, 2);
    cyc(4'd6, X_ALUWB, 2);

    // sw
    opcode = 7'b0100011;
    cyc(4'd0, X_FETCH_GO, 3);
    cyc(4'd1, X_DECODE, 3);
    cyc(4'd2, X_MEMADR, 3);
    cyc(4'd4, X_MEMWRITE, 3);

    // beq taken, beq not taken, bne
    opcode = 7'b1100011; funct3 = 3'b000; zero = 1'b1;
    cyc(4'd0, X_FETCH_GO, 4);
    cyc(4'd1, X_DECODE, 4);
    cyc(4'd8, X_BEQ_T, 4);
    zero = 1'b0;
    cyc(4'd0, X_FETCH_GO, 5);
    cyc(4'd1, X_DECODE, 5);
    cyc(4'd8, X_BEQ_N, 5);
    funct3 = 3'b001; zero = 1'b1;
    cyc(4'd0, X_FETCH_GO, 6);
    cyc(4'd1, X_DECODE, 6);
    cyc(4'd8, X_BNE, 6);

    // run low, then memory not ready, in FETCH
    opcode = 7'b0110011; funct3 = 3'b000; zero = 1'b0;
    run = 1'b0;
    repeat (5) cyc(4'd0, X_FETCH_IDLE, 7);
    run = 1'b1; mem_ready = 1'b0;
    repeat (2) cyc(4'd0, X_FETCH_WAIT, 7);
    mem_ready = 1'b1;

    // reset during EXECUTE abandons the add
    cyc(4'd0, X_FETCH_GO, 7);
    cyc(4'd1, X_DECODE, 7);
    rst = 1'b1;
    cyc(4'd5, X_RST, 7);
    rst = 1'b0;

    // illegal opcode parks in HALT
    opcode = 7'b1111111;
    cyc(4'd0, X_FETCH_GO, 0);
    cyc(4'd1, X_DECODE, 0);
    repeat (20) cyc(4'd9, X_HALT, 0);
    rst = 1'b1;
    cyc(4'd9, X_RST, 0);
    rst = 1'b0;
    opcode = 7'b0110011;
    cyc(4'd0, X_FETCH_GO, 0);

    @(negedge clk); #1;
    if (sb_q.size() != 0) begin
      n_miss++;
      $display("FAIL drain: got %0d pending expectations, want 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
